conv_result_uart_fmt: RTL and testbench
=======================================

Name: conv_result_uart_fmt

Overview:
- Downstream consumer of the 3x3 convolution engine's output stream: one 12-bit result per strobe, with row-end and last flags.
- Buffers results in an internal FIFO, because the producer has no backpressure.
- Converts each result to fixed-width decimal ASCII and streams the bytes to the board UART transmitter over a valid/ready byte handshake.
- Output is a printable 8x10 matrix: 3-char right-aligned fields, space-separated, rows ended by CR LF.

Parameters:
- ACC_WIDTH, 12, width of in_elem.
- DEPTH, 128, FIFO entries (power of 2, >= 4).
- AW, 7, FIFO address width, log2(DEPTH).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear: empties the FIFO, returns FSM to IDLE, clears sticky flags.
- in_valid  in  1  result strobe from the conv engine.
- in_elem  in  ACC_WIDTH  result value.
- in_row_end  in  1  result is the last column of its row.
- in_last  in  1  result is the final element of the frame.
- tx_data  out  8  ASCII byte to the UART TX.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART TX accepts the byte.
- busy  out  1  FIFO non-empty or FSM not in IDLE.
- frame_done  out  1  1-cycle pulse after the LF of an in_last element.
- overflow  out  1  sticky: a write was dropped because the FIFO was full.
- range_err  out  1  sticky: an element > 999 was formatted.
- fifo_count  out  AW+1  current FIFO occupancy.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock clk. All outputs reset to 0; FIFO empty; FSM in IDLE.
- clear: same end state as reset, taken at the next clk edge. clear has priority over in_valid in that cycle.
- FIFO:
  - Entry = {last, row_end, elem}; one write per cycle when in_valid && !full.
  - Full is decided on the pre-edge count. A write is rejected when full even if a pop happens in the same cycle.
  - A rejected write sets overflow; the element is lost.
  - Simultaneous push and pop when not full leaves fifo_count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, POP, CONV_H, CONV_T, SEND_D2, SEND_D1, SEND_D0, SEND_SEP, SEND_LF, FRAME.
- IDLE: if the FIFO is non-empty, go to POP.
- POP:
  - Pop the head and latch v = elem, flags = {last, row_end}; clear the hundreds and tens counters.
  - If elem > 999: set range_err, mark the entry "###", skip to SEND_D2.
  - Otherwise go to CONV_H.
- CONV_H: while v >= 100, subtract 100 and increment h, one subtraction per cycle; then go to CONV_T.
- CONV_T: while v >= 10, subtract 10 and increment t, one per cycle; the remainder is u; then go to SEND_D2.
- Maximum conversion time: 20 cycles (input 999).
- Send states: each holds tx_valid=1 with tx_data stable until a cycle with tx_ready=1. The transfer occurs on that edge and the next state follows.
  - SEND_D2: 0x20 if h==0, else 0x30+h.
  - SEND_D1: 0x20 if h==0 && t==0, else 0x30+t.
  - SEND_D0: 0x30+u.
  - Out-of-range entry: all three digit bytes are 0x23 ('#').
  - SEND_SEP: 0x0D if row_end, else 0x20. After a space, go to IDLE; after CR, go to SEND_LF.
  - SEND_LF: 0x0A. Then go to FRAME if last, else IDLE.
- FRAME: frame_done=1 for one cycle, then IDLE.
- tx_valid is registered and deasserts the cycle after the final accepted byte unless the next byte is already pending. No combinational path from tx_ready to tx_valid.
- Latency: with tx_ready held at 1, the first tx_valid rises no more than 24 cycles after in_valid into an empty FIFO. Throughput with tx_ready=1 is at least one element per 30 cycles, faster than the producer's ~11 cycles per element only when combined with FIFO depth; depth 128 absorbs a full 80-element frame.
- Reset or clear mid-send: tx_valid drops at once (asynchronously for reset) and the partial line is abandoned; no frame_done.
- in_row_end/in_last on an element dropped by overflow are lost; no frame_done for that frame.

Test Plan:
- Write elem=5, row_end=0 with tx_ready=1 -> bytes 0x20,0x20,0x35,0x20; busy falls afterwards; no frame_done.
- Write elem=729, row_end=1, last=1 -> bytes 0x37,0x32,0x39,0x0D,0x0A, then frame_done pulses exactly 1 cycle.
- Full 8x10 frame at 1 element per 11 cycles, tx_ready=0 until the frame ends, then tx_ready=1 -> fifo_count peaks at 80; 328 bytes total (41 per row); 8 CR LF pairs; overflow=0; one frame_done.
- tx_ready toggling pseudo-randomly during a frame -> tx_data never changes while tx_valid && !tx_ready; byte sequence identical to the tx_ready=1 run.
- DEPTH=4, AW=2, tx_ready=0, write 6 elements -> fifo_count=4, overflow=1; only the first 4 are printed after tx_ready=1. elem=1000 -> "###" and range_err=1.
- Assert rst_n low mid-SEND_D1 -> tx_valid=0 and fifo_count=0 immediately. After release, a new element formats correctly. clear behaves the same, taking effect on the next edge.

Source files
------------

// File: rtl/conv_result_uart_fmt.sv
// conv_result_uart_fmt: buffers 12-bit conv results in a FIFO and prints them
// as a 3-char right-aligned decimal matrix over a valid/ready UART byte port.
module conv_result_uart_fmt #(
  parameter int ACC_WIDTH = 12,
  parameter int DEPTH     = 128,
  parameter int AW        = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [ACC_WIDTH-1:0] in_elem,
  input  logic                 in_row_end,
  input  logic                 in_last,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overflow,
  output logic                 range_err,
  output logic [AW:0]          fifo_count
);

  localparam int EW = ACC_WIDTH + 2;
  localparam logic [7:0] ASCII_SP   = 8'h20;
  localparam logic [7:0] ASCII_HASH = 8'h23;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [3:0] {
    IDLE, POP, CONV_H, CONV_T, SEND_D2, SEND_D1, SEND_D0, SEND_SEP, SEND_LF, FRAME
  } state_t;

  logic [EW-1:0]        mem [DEPTH];
  logic [AW-1:0]        wrPtr_q, rdPtr_q;
  logic [AW:0]          count_q;
  logic                 overflow_q;
  logic                 full, push, pop;
  logic [EW-1:0]        head;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] v_q, v_d;
  logic [3:0]           h_q, h_d, t_q, t_d;
  logic                 bad_q, bad_d;
  logic                 rowEnd_q, rowEnd_d, last_q, last_d;
  logic                 rangeErr_q, rangeErr_d;
  logic [7:0]           txData_q, txData_d;
  logic                 txValid_q, txValid_d;
  logic                 frameDone_q, frameDone_d;

  // Full is judged on the pre-edge count, so a pop in the same cycle never
  // makes room for a write that arrives while full.
  assign full = (count_q == (AW+1)'(DEPTH));
  assign push = in_valid && !full && !clear;
  assign head = mem[rdPtr_q];

  // FIFO storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr_q] <= {in_last, in_row_end, in_elem};
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
      if (in_valid && full) overflow_q <= 1'b1;
    end
  end

  // Next-state logic: pop, repeated-subtraction BCD split, then byte sends.
  always_comb begin
    state_d    = state_q;
    v_d        = v_q;
    h_d        = h_q;
    t_d        = t_q;
    bad_d      = bad_q;
    rowEnd_d   = rowEnd_q;
    last_d     = last_q;
    rangeErr_d = rangeErr_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: if (count_q != '0) state_d = POP;
      POP: begin
        pop      = 1'b1;
        v_d      = head[ACC_WIDTH-1:0];
        rowEnd_d = head[ACC_WIDTH];
        last_d   = head[ACC_WIDTH+1];
        h_d      = '0;
        t_d      = '0;
        if (head[ACC_WIDTH-1:0] > ACC_WIDTH'(999)) begin
          bad_d      = 1'b1;
          rangeErr_d = 1'b1;
          state_d    = SEND_D2;
        end else begin
          bad_d   = 1'b0;
          state_d = CONV_H;
        end
      end
      CONV_H: begin
        if (v_q >= ACC_WIDTH'(100)) begin
          v_d = v_q - ACC_WIDTH'(100);
          h_d = h_q + 4'd1;
        end else begin
          state_d = CONV_T;
        end
      end
      CONV_T: begin
        if (v_q >= ACC_WIDTH'(10)) begin
          v_d = v_q - ACC_WIDTH'(10);
          t_d = t_q + 4'd1;
        end else begin
          state_d = SEND_D2;
        end
      end
      SEND_D2:  if (tx_ready) state_d = SEND_D1;
      SEND_D1:  if (tx_ready) state_d = SEND_D0;
      SEND_D0:  if (tx_ready) state_d = SEND_SEP;
      SEND_SEP: if (tx_ready) state_d = rowEnd_q ? SEND_LF : IDLE;
      SEND_LF:  if (tx_ready) state_d = last_q ? FRAME : IDLE;
      FRAME:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (clear) begin
      state_d    = IDLE;
      rangeErr_d = 1'b0;
      pop        = 1'b0;
    end
  end

  // Output bytes are decoded from the next state so tx_valid/tx_data are
  // plain flops with no combinational path from tx_ready.
  always_comb begin
    txValid_d   = 1'b1;
    txData_d    = 8'h00;
    frameDone_d = (state_d == FRAME);
    case (state_d)
      SEND_D2:  txData_d = bad_d ? ASCII_HASH :
                           (h_d == 4'd0) ? ASCII_SP : (ASCII_ZERO + {4'h0, h_d});
      SEND_D1:  txData_d = bad_d ? ASCII_HASH :
                           (h_d == 4'd0 && t_d == 4'd0) ? ASCII_SP : (ASCII_ZERO + {4'h0, t_d});
      SEND_D0:  txData_d = bad_d ? ASCII_HASH : (ASCII_ZERO + {4'h0, v_d[3:0]});
      SEND_SEP: txData_d = rowEnd_d ? ASCII_CR : ASCII_SP;
      SEND_LF:  txData_d = ASCII_LF;
      default:  txValid_d = 1'b0;
    endcase
  end

  // FSM, conversion datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      v_q         <= '0;
      h_q         <= '0;
      t_q         <= '0;
      bad_q       <= 1'b0;
      rowEnd_q    <= 1'b0;
      last_q      <= 1'b0;
      rangeErr_q  <= 1'b0;
      txData_q    <= '0;
      txValid_q   <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      h_q         <= h_d;
      t_q         <= t_d;
      bad_q       <= bad_d;
      rowEnd_q    <= rowEnd_d;
      last_q      <= last_d;
      rangeErr_q  <= rangeErr_d;
      txData_q    <= txData_d;
      txValid_q   <= txValid_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign tx_data    = txData_q;
  assign tx_valid   = txValid_q;
  assign frame_done = frameDone_q;
  assign overflow   = overflow_q;
  assign range_err  = rangeErr_q;
  assign fifo_count = count_q;
  assign busy       = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_conv_result_uart_fmt.sv
// tb_conv_result_uart_fmt: scoreboard bench; a decimal-formatting model queues
// the expected bytes at write time and monitors pop them as the DUTs send.
module tb_conv_result_uart_fmt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        inValid = 1'b0;
  logic [11:0] inElem = '0;
  logic        inRowEnd = 1'b0, inLast = 1'b0;
  logic [7:0]  txData;
  logic        txValid, txReady, busy, frameDone, overflow, rangeErr;
  logic [7:0]  fifoCount;
  logic        readyCmd = 1'b0, randomMode = 1'b0, rndReady = 1'b0;

  logic        clearS = 1'b0;
  logic        inValidS = 1'b0;
  logic [11:0] inElemS = '0;
  logic        inRowEndS = 1'b0, inLastS = 1'b0;
  logic [7:0]  txDataS;
  logic        txValidS, busyS, frameDoneS, overflowS, rangeErrS;
  logic        txReadyS = 1'b0;
  logic [2:0]  fifoCountS;

  logic [8:0]  expQ[$];
  logic [8:0]  expQS[$];
  int          errCount = 0, checkCount = 0;
  int          byteCount = 0, crCount = 0, lfCount = 0, fdPulses = 0, peakCount = 0;
  bit          checkFd = 0, fdExpected = 0, prevFd = 0, holdPrev = 0;
  logic [7:0]  holdData = '0;

  assign txReady = randomMode ? rndReady : readyCmd;

  always #5 clk = ~clk;

  conv_result_uart_fmt dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(inValid), .in_elem(inElem),
    .in_row_end(inRowEnd), .in_last(inLast), .tx_data(txData), .tx_valid(txValid),
    .tx_ready(txReady), .busy(busy), .frame_done(frameDone), .overflow(overflow),
    .range_err(rangeErr), .fifo_count(fifoCount)
  );

  conv_result_uart_fmt #(.ACC_WIDTH(12), .DEPTH(4), .AW(2)) dutSmall (
    .clk(clk), .rst_n(rst_n), .clear(clearS), .in_valid(inValidS), .in_elem(inElemS),
    .in_row_end(inRowEndS), .in_last(inLastS), .tx_data(txDataS), .tx_valid(txValidS),
    .tx_ready(txReadyS), .busy(busyS), .frame_done(frameDoneS), .overflow(overflowS),
    .range_err(rangeErrS), .fifo_count(fifoCountS)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference formatter: digits via division, bit 8 marks the LF of a last element.
  task automatic pushExpected(input bit toSmall, input int elem, input bit rowEnd, input bit last);
    logic [8:0] b [5];
    int n, h, t, u;
    if (elem > 999) begin
      b[0] = 9'h023; b[1] = 9'h023; b[2] = 9'h023;
    end else begin
      h = elem / 100; t = (elem / 10) % 10; u = elem % 10;
      b[0] = (h == 0) ? 9'h020 : 9'(8'h30 + h);
      b[1] = (h == 0 && t == 0) ? 9'h020 : 9'(8'h30 + t);
      b[2] = 9'(8'h30 + u);
    end
    b[3] = rowEnd ? 9'h00D : 9'h020;
    b[4] = {last, 8'h0A};
    n = rowEnd ? 5 : 4;
    for (int i = 0; i < n; i++) begin
      if (toSmall) expQS.push_back(b[i]);
      else expQ.push_back(b[i]);
    end
  endtask

  task automatic applyStimulus(input bit toSmall, input int elem, input bit rowEnd,
                               input bit last, input bit kept);
    @(negedge clk);
    if (toSmall) begin
      inValidS = 1'b1; inElemS = 12'(elem); inRowEndS = rowEnd; inLastS = last;
    end else begin
      inValid = 1'b1; inElem = 12'(elem); inRowEnd = rowEnd; inLast = last;
    end
    if (kept) pushExpected(toSmall, elem, rowEnd, last);
    @(negedge clk);
    inValid = 1'b0; inValidS = 1'b0;
  endtask

  task automatic waitDrain(input bit toSmall, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (toSmall && !busyS && !txValidS && expQS.size() == 0) break;
      if (!toSmall && !busy && !txValid && expQ.size() == 0) break;
    end
    if (toSmall) begin
      checkOutput("drainBusyS", busyS, 0);
      checkOutput("drainQueueS", expQS.size(), 0);
    end else begin
      checkOutput("drainBusy", busy, 0);
      checkOutput("drainQueue", expQ.size(), 0);
    end
  endtask

  task automatic waitTxValid(input int budget);
    for (int i = 0; i < budget && !txValid; i++) @(negedge clk);
    checkOutput("waitValid", txValid, 1);
  endtask

  function automatic int frameVal(input int i);
    case (i)
      0: return 0;   1: return 9;   2: return 10;  3: return 99;
      4: return 100; 5: return 999; 6: return 408; 7: return 50;
      default: return (i * 137) % 1000;
    endcase
  endfunction

  task automatic sendFrame();
    for (int i = 0; i < 80; i++) begin
      applyStimulus(0, frameVal(i), (i % 10) == 9, i == 79, 1);
      repeat (9) @(negedge clk);
    end
  endtask

  always @(negedge clk) rndReady = 1'($urandom_range(0, 1));

  // Main-DUT monitor: byte scoreboard, hold stability, frame_done placement.
  always begin
    logic [8:0] e;
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (32'(fifoCount) > 32'(peakCount)) peakCount = int'(fifoCount);
      if (checkFd) begin
        checkOutput("frameDoneAfterLf", frameDone, fdExpected);
        checkFd = 0;
      end
      if (frameDone) begin
        fdPulses++;
        checkOutput("frameDoneWidth", prevFd, 0);
      end
      if (holdPrev) begin
        checkOutput("holdValid", txValid, 1);
        checkOutput("holdData", txData, holdData);
      end
      if (txValid && txReady) begin
        if (expQ.size() == 0) begin
          checkOutput("extraByte", txData, 32'h100);
        end else begin
          e = expQ.pop_front();
          checkOutput("byte", txData, e[7:0]);
          byteCount++;
          if (txData == 8'h0D) crCount++;
          if (txData == 8'h0A) lfCount++;
          if (e[7:0] == 8'h0A) begin
            checkFd = 1;
            fdExpected = e[8];
          end
        end
      end
      holdPrev = txValid && !txReady && !clear;
      holdData = txData;
    end else begin
      holdPrev = 0;
      checkFd = 0;
    end
    prevFd = frameDone;
  end

  // Small-DUT monitor: byte scoreboard only.
  always begin
    logic [8:0] e;
    @(negedge clk);
    #1;
    if (rst_n && txValidS && txReadyS) begin
      if (expQS.size() == 0) begin
        checkOutput("extraByteS", txDataS, 32'h100);
      end else begin
        e = expQS.pop_front();
        checkOutput("byteS", txDataS, e[7:0]);
      end
    end
  end

  initial begin
    int fdStart, byteStart, crStart, lfStart, lat;

    repeat (3) @(negedge clk);
    checkOutput("rstTxValid", txValid, 0);
    checkOutput("rstTxData", txData, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstFrameDone", frameDone, 0);
    checkOutput("rstOverflow", overflow, 0);
    checkOutput("rstRangeErr", rangeErr, 0);
    checkOutput("rstFifoCount", fifoCount, 0);
    rst_n = 1'b1;

    $display("[TB] single element 5");
    readyCmd = 1'b1;
    fdStart = fdPulses; byteStart = byteCount;
    applyStimulus(0, 5, 0, 0, 1);
    waitDrain(0, 200);
    checkOutput("t1Bytes", byteCount - byteStart, 4);
    checkOutput("t1NoFrameDone", fdPulses - fdStart, 0);

    $display("[TB] element 729 with row end and last");
    fdStart = fdPulses; byteStart = byteCount;
    applyStimulus(0, 729, 1, 1, 1);
    waitDrain(0, 200);
    checkOutput("t2Bytes", byteCount - byteStart, 5);
    checkOutput("t2FrameDone", fdPulses - fdStart, 1);

    $display("[TB] worst-case latency for 999");
    pushExpected(0, 999, 0, 0);
    @(negedge clk);
    inValid = 1'b1; inElem = 12'd999; inRowEnd = 1'b0; inLast = 1'b0;
    @(negedge clk);
    inValid = 1'b0;
    lat = 1;
    while (lat < 40 && !txValid) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latencyWithin24", lat <= 24, 1);
    waitDrain(0, 200);

    $display("[TB] small FIFO overflow");
    applyStimulus(1, 321, 0, 0, 1);
    for (int i = 0; i < 60 && !txValidS; i++) @(negedge clk);
    checkOutput("smallBlockerValid", txValidS, 1);
    for (int i = 0; i < 6; i++) applyStimulus(1, 11 * (i + 1), 0, 0, i < 4);
    checkOutput("smallFifoCount", fifoCountS, 4);
    checkOutput("smallOverflow", overflowS, 1);
    txReadyS = 1'b1;
    waitDrain(1, 1000);
    checkOutput("smallOverflowSticky", overflowS, 1);

    $display("[TB] out-of-range element");
    applyStimulus(0, 1000, 0, 0, 1);
    waitDrain(0, 200);
    checkOutput("rangeErrSet", rangeErr, 1);

    $display("[TB] full frame behind a stalled element");
    readyCmd = 1'b0;
    fdStart = fdPulses; byteStart = byteCount; crStart = crCount; lfStart = lfCount;
    applyStimulus(0, 7, 1, 0, 1);
    waitTxValid(60);
    peakCount = 0;
    sendFrame();
    checkOutput("framePeakCount", peakCount, 80);
    checkOutput("frameOverflow", overflow, 0);
    readyCmd = 1'b1;
    waitDrain(0, 6000);
    checkOutput("frameBytes", byteCount - byteStart, 5 + 328);
    checkOutput("frameCr", crCount - crStart, 1 + 8);
    checkOutput("frameLf", lfCount - lfStart, 1 + 8);
    checkOutput("frameDoneCount", fdPulses - fdStart, 1);

    $display("[TB] full frame with random tx_ready");
    randomMode = 1'b1;
    fdStart = fdPulses; byteStart = byteCount;
    sendFrame();
    waitDrain(0, 10000);
    randomMode = 1'b0;
    checkOutput("randBytes", byteCount - byteStart, 328);
    checkOutput("randFrameDone", fdPulses - fdStart, 1);
    checkOutput("randOverflow", overflow, 0);

    $display("[TB] reset during second digit");
    readyCmd = 1'b0;
    applyStimulus(0, 321, 0, 0, 1);
    waitTxValid(60);
    @(negedge clk) readyCmd = 1'b1;
    @(negedge clk) readyCmd = 1'b0;
    #2;
    checkOutput("preRstValid", txValid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstMidValid", txValid, 0);
    checkOutput("rstMidCount", fifoCount, 0);
    checkOutput("rstMidBusy", busy, 0);
    checkOutput("rstMidRangeErr", rangeErr, 0);
    expQ.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    readyCmd = 1'b1;
    fdStart = fdPulses;
    applyStimulus(0, 408, 0, 0, 1);
    waitDrain(0, 200);
    checkOutput("postRstNoFrameDone", fdPulses - fdStart, 0);

    $display("[TB] clear during second digit");
    readyCmd = 1'b0;
    applyStimulus(0, 1000, 1, 1, 1);
    waitTxValid(60);
    @(negedge clk) readyCmd = 1'b1;
    @(negedge clk) readyCmd = 1'b0;
    clear = 1'b1; inValid = 1'b1; inElem = 12'd55;
    #2;
    checkOutput("clrPendingValid", txValid, 1);
    checkOutput("clrPendingRangeErr", rangeErr, 1);
    @(negedge clk);
    clear = 1'b0; inValid = 1'b0;
    #2;
    checkOutput("clrValid", txValid, 0);
    checkOutput("clrCount", fifoCount, 0);
    checkOutput("clrBusy", busy, 0);
    checkOutput("clrRangeErr", rangeErr, 0);
    expQ.delete();
    readyCmd = 1'b1;
    fdStart = fdPulses;
    applyStimulus(0, 60, 1, 1, 1);
    waitDrain(0, 200);
    checkOutput("postClrFrameDone", fdPulses - fdStart, 1);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
